// File: rtl/bcd_divcheck_stream_if.sv
// Digit-stream handshake and result bus for bcd_divcheck_stream.
// The master side is the digit source; the slave side is the checker.
interface bcd_divcheck_stream_if #(
    parameter int MAX_DIGITS = 8,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
);
    logic             start;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             digit_last;
    logic             in_ready;
    logic             done;
    logic [1:0]       mod3;
    logic [3:0]       mod11;
    logic             div3;
    logic             div11;
    logic [CNT_W-1:0] ndigits;
    logic             err;

    modport master (
        output start, digit, digit_valid, digit_last,
        input  in_ready, done, mod3, mod11, div3, div11, ndigits, err
    );

    modport slave (
        input  start, digit, digit_valid, digit_last,
        output in_ready, done, mod3, mod11, div3, div11, ndigits, err
    );
endinterface

// File: rtl/bcd_divcheck_stream.sv
// Streaming BCD checker: folds one digit per accepted beat (MSD first) into
// running mod-3 and mod-11 remainders and reports divisibility when done.
module bcd_divcheck_stream #(
    parameter int MAX_DIGITS = 8,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input logic                  clk,
    input logic                  rst_n,
    bcd_divcheck_stream_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [1:0]       r3;
    logic [3:0]       r11;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             div3_q;
    logic             div11_q;
    logic             in_ready_q;
    logic             done_q;

    logic [4:0]       sum3;
    logic [1:0]       r3_next;
    logic [4:0]       alt11;
    logic [3:0]       r11_next;
    logic [CNT_W-1:0] cnt_next;
    logic             err_next;
    logic             accept;
    logic             finish;

    // Horner steps: 10 == 1 (mod 3) adds the digit, 10 == -1 (mod 11) negates r11.
    always_comb begin
        sum3     = 5'(r3) + 5'(bus.digit);
        r3_next  = 2'(sum3 % 5'd3);
        alt11    = 5'(bus.digit) + 5'd11 - 5'(r11);
        r11_next = (alt11 >= 5'd11) ? 4'(alt11 - 5'd11) : alt11[3:0];
        cnt_next = cnt + CNT_W'(1);
        err_next = err_q || (bus.digit > 4'd9);
        accept   = bus.digit_valid && in_ready_q;
        finish   = bus.digit_last || (cnt_next == CNT_W'(MAX_DIGITS));
    end

    // NOTE: all state lives in one clocked block with non-blocking assignments
    // and an async reset, so every output is registered and glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            r3         <= '0;
            r11        <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            div3_q     <= 1'b0;
            div11_q    <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r3         <= '0;
                        r11        <= '0;
                        cnt        <= '0;
                        err_q      <= 1'b0;
                        div3_q     <= 1'b0;
                        div11_q    <= 1'b0;
                        in_ready_q <= 1'b1;
                        done_q     <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        r3    <= r3_next;
                        r11   <= r11_next;
                        cnt   <= cnt_next;
                        err_q <= err_next;
                        if (finish) begin
                            div3_q     <= (r3_next == 2'd0) && !err_next;
                            div11_q    <= (r11_next == 4'd0) && !err_next;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                default: begin
                    in_ready_q <= 1'b0;
                    done_q     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.done     = done_q;
    assign bus.mod3     = r3;
    assign bus.mod11    = r11;
    assign bus.div3     = div3_q;
    assign bus.div11    = div11_q;
    assign bus.ndigits  = cnt;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_bcd_divcheck_stream.sv
// Directed bench for bcd_divcheck_stream: an arithmetic model pushes expected
// results to a scoreboard as digits are driven; they are popped when done rises.
module tb_bcd_divcheck_stream;
    localparam int MAX_DIGITS = 8;
    localparam int CNT_W      = $clog2(MAX_DIGITS + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    bcd_divcheck_stream_if #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) bus ();

    bcd_divcheck_stream #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int mod3;
        int mod11;
        int div3;
        int div11;
        int ndigits;
        int err;
    } result_t;

    result_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    int m3, m11, mcnt, merr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m3   = 0;
        m11  = 0;
        mcnt = 0;
        merr = 0;
    endtask

    // All stimulus tasks begin and end on a falling edge.
    task automatic do_start(input logic with_digit);
        bus.start       = 1'b1;
        bus.digit_valid = with_digit;
        bus.digit       = 4'd5;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.digit_valid = 1'b0;
        model_clear();
    endtask

    task automatic send_digit(input logic [3:0] d, input logic last);
        result_t r;
        bus.digit       = d;
        bus.digit_last  = last;
        bus.digit_valid = 1'b1;
        @(negedge clk);
        bus.digit_valid = 1'b0;
        bus.digit_last  = 1'b0;
        m3   = (m3 * 10 + int'(d)) % 3;
        m11  = (m11 * 10 + int'(d)) % 11;
        mcnt = mcnt + 1;
        if (d > 4'd9) merr = 1;
        if (last || mcnt == MAX_DIGITS) begin
            r.mod3    = m3;
            r.mod11   = m11;
            r.div3    = (m3 == 0 && merr == 0) ? 1 : 0;
            r.div11   = (m11 == 0 && merr == 0) ? 1 : 0;
            r.ndigits = mcnt;
            r.err     = merr;
            sb.push_back(r);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic collect(input string name);
        result_t r;
        check({name, "_latency"}, bus.done, 1);
        for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
        check({name, "_done"}, bus.done, 1);
        if (sb.size() != 0) begin
            r = sb.pop_front();
            check({name, "_mod3"}, bus.mod3, r.mod3);
            check({name, "_mod11"}, bus.mod11, r.mod11);
            check({name, "_div3"}, bus.div3, r.div3);
            check({name, "_div11"}, bus.div11, r.div11);
            check({name, "_ndigits"}, bus.ndigits, r.ndigits);
            check({name, "_err"}, bus.err, r.err);
            check({name, "_in_ready"}, bus.in_ready, 0);
        end
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_done"}, bus.done, 0);
        check({name, "_in_ready"}, bus.in_ready, 0);
        check({name, "_mod3"}, bus.mod3, 0);
        check({name, "_mod11"}, bus.mod11, 0);
        check({name, "_div3"}, bus.div3, 0);
        check({name, "_div11"}, bus.div11, 0);
        check({name, "_ndigits"}, bus.ndigits, 0);
        check({name, "_err"}, bus.err, 0);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.digit       = 4'd0;
        bus.digit_valid = 1'b0;
        bus.digit_last  = 1'b0;
        model_clear();

        #2 rst_n = 1'b0;
        #1 check_reset_values("rst");
        gap(2);
        rst_n = 1'b1;
        @(negedge clk);

        // A digit offered alongside start in IDLE must be ignored.
        do_start(1'b1);
        check("start_ign_ndigits", bus.ndigits, 0);
        check("start_in_ready", bus.in_ready, 1);
        send_digit(4'd1, 1'b0);
        send_digit(4'd2, 1'b0);
        send_digit(4'd3, 1'b0);
        send_digit(4'd4, 1'b1);
        collect("n1234");

        do_start(1'b0);
        send_digit(4'd9, 1'b0);
        send_digit(4'd9, 1'b0);
        send_digit(4'd9, 1'b0);
        send_digit(4'd9, 1'b1);
        collect("n9999");

        // Restart out of DONE clears the registered flags.
        do_start(1'b0);
        check("restart_div3", bus.div3, 0);
        check("restart_div11", bus.div11, 0);
        check("restart_done", bus.done, 0);
        check("restart_ndigits", bus.ndigits, 0);
        send_digit(4'd0, 1'b1);
        collect("n0");

        // Implicit termination on the MAX_DIGITS-th digit.
        do_start(1'b0);
        for (int d = 1; d <= MAX_DIGITS; d++) send_digit(4'(d), 1'b0);
        collect("nmax");
        bus.digit       = 4'd7;
        bus.digit_valid = 1'b1;
        bus.digit_last  = 1'b1;
        gap(3);
        bus.digit_valid = 1'b0;
        bus.digit_last  = 1'b0;
        check("hold_ndigits", bus.ndigits, MAX_DIGITS);
        check("hold_mod11", bus.mod11, 4);
        check("hold_done", bus.done, 1);

        do_start(1'b0);
        send_digit(4'd3, 1'b0);
        send_digit(4'hA, 1'b0);
        send_digit(4'd3, 1'b1);
        collect("n3a3");

        do_start(1'b0);
        send_digit(4'd3, 1'b0);
        send_digit(4'd3, 1'b1);
        collect("n33");

        // Gapped stream with a start pulse while in RUN.
        do_start(1'b0);
        send_digit(4'd1, 1'b0);
        gap(1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        gap(1);
        bus.digit_last = 1'b1;
        gap(1);
        bus.digit_last = 1'b0;
        check("gap_ndigits", bus.ndigits, 1);
        send_digit(4'd2, 1'b0);
        gap(3);
        send_digit(4'd1, 1'b1);
        collect("n121");

        // Asynchronous reset mid-number discards the partial result.
        do_start(1'b0);
        send_digit(4'd5, 1'b0);
        send_digit(4'd8, 1'b0);
        check("mid_mod3", bus.mod3, 1);
        check("mid_mod11", bus.mod11, 3);
        check("mid_ndigits", bus.ndigits, 2);
        #3 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(1'b0);
        send_digit(4'd6, 1'b0);
        send_digit(4'd6, 1'b1);
        collect("n66");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
